// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: reads the rasterizer's pixel FIFO, unpacks each word into
// coordinates and an RGB666 colour, and drops pixels outside H_RES x V_RES.
// In-bounds pixels are written to the framebuffer at y*H_RES + x.
// A clear_req pulse fills every address with CLEAR_COLOR.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   empty, rd_en, rd_data pixel FIFO interface; data is valid the cycle after rd_en
//   mem_addr/wdata/we/ack framebuffer write handshake; mem_we is held until acked
//   clear_req, clear_busy clear request pulse, and the busy flag for the sweep
//   pix_count, drop_count pixels written and off-screen pixels dropped since reset
module fb_pixel_writer #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter logic [17:0] CLEAR_COLOR = 18'h00000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              empty,
  output logic              rd_en,
  input  logic [95:0]       rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [17:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [31:0]       pix_count,
  output logic [31:0]       drop_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [17:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                pend_q, pend_d;
  logic [31:0]         pix_q, pix_d;
  logic [31:0]         drop_q, drop_d;
  logic                rd_en_c;

  // Unpacked fields of the FIFO word.
  logic [8:0]          px_y;
  logic [9:0]          px_x;
  logic [17:0]         px_rgb;
  logic                px_off;
  logic [31:0]         px_lin;

  assign px_y   = rd_data[88:80];
  assign px_x   = rd_data[73:64];
  assign px_rgb = {rd_data[55:50], rd_data[47:42], rd_data[39:34]};
  assign px_off = (32'(px_x) >= H_RES) || (32'(px_y) >= V_RES);
  assign px_lin = 32'(px_y) * H_RES + 32'(px_x);

  logic unused_bits;
  assign unused_bits = ^{rd_data[95:89], rd_data[79:74], rd_data[63:56],
                         rd_data[49:48], rd_data[41:40], rd_data[33:0],
                         px_lin[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      pix_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      pix_q   <= pix_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    busy_d  = busy_q;
    pix_d   = pix_q;
    drop_d  = drop_q;
    rd_en_c = 1'b0;
    // A request is remembered everywhere except during the sweep itself.
    pend_d  = pend_q | (clear_req && (state_q != S_CLEAR));

    case (state_q)
      S_IDLE: begin
        if (pend_q || clear_req) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          addr_d  = '0;
          wdata_d = CLEAR_COLOR;
          we_d    = 1'b1;
        end else if (!empty) begin
          rd_en_c = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (px_off) begin
          drop_d  = drop_q + 32'd1;
          state_d = S_IDLE;
        end else begin
          addr_d  = px_lin[ADDR_W-1:0];
          wdata_d = px_rgb;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          we_d    = 1'b0;
          pix_d   = pix_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (mem_ack) begin
          if (addr_q == LAST_ADDR) begin
            we_d    = 1'b0;
            busy_d  = 1'b0;
            addr_d  = '0;
            state_d = S_IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pop strobe is combinational so it always reflects this cycle's empty;
  // gating with rst_n keeps a held reset from popping the FIFO.
  assign rd_en      = rd_en_c & rst_n;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = we_q;
  assign clear_busy = busy_q;
  assign pix_count  = pix_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: a default-size instance for pixel traffic and a
// small-screen instance so that full clear sweeps stay short.
module tb_fb_pixel_writer;

  localparam int unsigned S_H = 40;
  localparam int unsigned S_V = 30;
  localparam logic [17:0] S_CLR = 18'h2AB55;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance signals.
  logic        rst_n, empty, rd_en, mem_we, mem_ack, clear_req, clear_busy;
  logic [95:0] rd_data;
  logic [18:0] mem_addr;
  logic [17:0] mem_wdata;
  logic [31:0] pix_count, drop_count;

  // Small-screen instance signals.
  logic        s_rst_n, s_empty, s_rd_en, s_mem_we, s_mem_ack, s_clear_req, s_clear_busy;
  logic [95:0] s_rd_data;
  logic [10:0] s_mem_addr;
  logic [17:0] s_mem_wdata;
  logic [31:0] s_pix, s_drop;

  fb_pixel_writer u_dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rd_en(rd_en), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ack(mem_ack),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .pix_count(pix_count), .drop_count(drop_count)
  );

  fb_pixel_writer #(
    .H_RES(S_H), .V_RES(S_V), .ADDR_W(11), .CLEAR_COLOR(S_CLR)
  ) u_small (
    .clk(clk), .rst_n(s_rst_n), .empty(s_empty), .rd_en(s_rd_en), .rd_data(s_rd_data),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we), .mem_ack(s_mem_ack),
    .clear_req(s_clear_req), .clear_busy(s_clear_busy),
    .pix_count(s_pix), .drop_count(s_drop)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [95:0] mk_word(input logic [9:0] x, input logic [8:0] y,
                                          input logic [5:0] r, input logic [5:0] g,
                                          input logic [5:0] b);
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    w[73:64] = x;
    w[88:80] = y;
    w[55:50] = r;
    w[47:42] = g;
    w[39:34] = b;
    return w;
  endfunction

  // Reference model: FIFO contents, writes the model expects, and counters.
  typedef struct { logic [18:0] a; logic [17:0] d; } wr_t;
  logic [95:0] fifo_q[$];
  wr_t         exp_q[$];
  int          exp_pix = 0, exp_drop = 0, rd_pulses = 0, we_cycles = 0;
  int unsigned ack_rate = 100;
  bit          ack_manual = 1'b0;
  logic        obs_rd, obs_we, obs_ack;
  logic [18:0] obs_addr, last_a;
  logic [17:0] obs_data, last_d;

  task automatic model_pop(input logic [95:0] w);
    int x, y;
    wr_t e;
    x = int'(w[73:64]);
    y = int'(w[88:80]);
    if (x < 640 && y < 480) begin
      e.a = 19'(y * 640 + x);
      e.d = {w[55:50], w[47:42], w[39:34]};
      exp_q.push_back(e);
      exp_pix++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic push_word(input logic [95:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock of the default instance: observe before the edge, drive after it.
  task automatic cycle();
    logic [95:0] popw;
    bit got_pop;
    got_pop = 1'b0;
    popw = '0;
    @(negedge clk);
    obs_rd = rd_en; obs_we = mem_we; obs_ack = mem_ack;
    obs_addr = mem_addr; obs_data = mem_wdata;
    if (obs_rd) begin
      rd_pulses++;
      check("pop_nonempty", empty, 0);
      if (fifo_q.size() > 0) begin
        popw = fifo_q.pop_front();
        got_pop = 1'b1;
        model_pop(popw);
      end
    end
    if (obs_we) begin
      we_cycles++;
      check("we_has_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("wr_addr", obs_addr, exp_q[0].a);
        check("wr_data", obs_data, exp_q[0].d);
        if (obs_ack) begin
          void'(exp_q.pop_front());
          last_a = obs_addr;
          last_d = obs_data;
        end
      end
    end
    @(posedge clk);
    #1;
    rd_data = got_pop ? popw : {$urandom, $urandom, $urandom};
    empty = (fifo_q.size() == 0);
    if (!ack_manual) mem_ack = ($urandom_range(0, 99) < ack_rate);
  endtask

  task automatic drain(input int max_cycles);
    int quiet;
    quiet = 0;
    for (int i = 0; i < max_cycles && quiet < 3; i++) begin
      cycle();
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !obs_we && !obs_rd) quiet++;
      else quiet = 0;
    end
    check("drain_done", quiet >= 3, 1);
  endtask

  // Small instance: follow a clear sweep from its first write to its end.
  task automatic s_sweep(output int n, output int bad);
    n = 0;
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!s_clear_busy) break;
      if (!s_mem_we || s_mem_addr != 11'(n) || s_mem_wdata != S_CLR || s_rd_en) bad++;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [5:0]  r, g, b;
    logic        wr;
    logic [18:0] a;
    logic [17:0] d;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int   tbl_pix, tbl_drop, rp0, we0, n, bad, pushed;
    bit   found;

    tbl[0] = '{10'd5,    9'd2,   6'h3F, 6'h15, 6'h2A, 1'b1, 19'd1285,   18'h3F56A};
    tbl[1] = '{10'd640,  9'd0,   6'h01, 6'h01, 6'h01, 1'b0, 19'd0,      18'h0};
    tbl[2] = '{10'd0,    9'd480, 6'h02, 6'h02, 6'h02, 1'b0, 19'd0,      18'h0};
    tbl[3] = '{10'd639,  9'd479, 6'h01, 6'h02, 6'h03, 1'b1, 19'd307199, 18'h01083};
    tbl[4] = '{10'd0,    9'd0,   6'h00, 6'h00, 6'h00, 1'b1, 19'd0,      18'h00000};
    tbl[5] = '{10'd1023, 9'd511, 6'h3F, 6'h3F, 6'h3F, 1'b0, 19'd0,      18'h0};
    tbl[6] = '{10'd639,  9'd0,   6'h3F, 6'h3F, 6'h3F, 1'b1, 19'd639,    18'h3FFFF};
    tbl[7] = '{10'd0,    9'd479, 6'h2A, 6'h15, 6'h3F, 1'b1, 19'd306560, 18'h2A57F};
    tbl[8] = '{10'd640,  9'd480, 6'h11, 6'h22, 6'h33, 1'b0, 19'd0,      18'h0};

    rst_n = 1'b0; empty = 1'b1; mem_ack = 1'b0; clear_req = 1'b0; rd_data = '0;
    s_rst_n = 1'b0; s_empty = 1'b1; s_mem_ack = 1'b1; s_clear_req = 1'b0; s_rd_data = '0;
    last_a = '0; last_d = '0;

    // Reset, then idle with an empty FIFO.
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle_rd_en", obs_rd, 0);
      check("idle_mem_we", obs_we, 0);
      check("idle_busy", clear_busy, 0);
      check("idle_pix", pix_count, 0);
      check("idle_drop", drop_count, 0);
    end
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);

    // Directed pixel vectors with immediate ack.
    ack_rate = 100;
    tbl_pix = 0;
    tbl_drop = 0;
    foreach (tbl[i]) begin
      rp0 = rd_pulses;
      we0 = we_cycles;
      push_word(mk_word(tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].g, tbl[i].b));
      drain(40);
      if (tbl[i].wr) tbl_pix++;
      else tbl_drop++;
      check("tbl_rd_pulses", rd_pulses - rp0, 1);
      check("tbl_we_cycles", we_cycles - we0, 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        check("tbl_addr", last_a, tbl[i].a);
        check("tbl_data", last_d, tbl[i].d);
      end
      check("tbl_pix", pix_count, tbl_pix);
      check("tbl_drop", drop_count, tbl_drop);
    end

    // Ack stall: ack low for 7 mem_we cycles, high on the 8th.
    ack_manual = 1'b1;
    mem_ack = 1'b0;
    push_word(mk_word(10'd10, 9'd20, 6'h05, 6'h06, 6'h07));
    push_word(mk_word(10'd11, 9'd20, 6'h08, 6'h09, 6'h0A));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = obs_we;
    end
    check("stall_we_rise", found, 1);
    for (int k = 2; k <= 8; k++) begin
      if (k == 8) mem_ack = 1'b1;
      cycle();
      check("stall_we_held", obs_we, 1);
      check("stall_no_rd", obs_rd, 0);
    end
    check("stall_addr", last_a, 19'd12810);
    cycle();
    check("stall_we_drop", obs_we, 0);
    check("stall_pix_once", pix_count, tbl_pix + 1);
    ack_manual = 1'b0;
    ack_rate = 100;
    drain(60);
    check("stall_pix_after", pix_count, tbl_pix + 2);

    // Randomized traffic with random ack pacing against the model.
    pushed = 0;
    for (int i = 0; i < 3000 && pushed < 150; i++) begin
      logic [9:0] rx;
      logic [8:0] ry;
      if ($urandom_range(0, 15) == 0) ack_rate = $urandom_range(20, 100);
      if ($urandom_range(0, 2) == 0) begin
        rx = 10'($urandom_range(0, 700));
        ry = 9'($urandom_range(0, 530));
        if ($urandom_range(0, 9) == 0) rx = 10'($urandom);
        if ($urandom_range(0, 9) == 0) ry = 9'($urandom);
        push_word(mk_word(rx, ry, 6'($urandom), 6'($urandom), 6'($urandom)));
        pushed++;
      end
      cycle();
    end
    ack_rate = 100;
    drain(3000);
    check("rand_pix", pix_count, exp_pix);
    check("rand_drop", drop_count, exp_drop);
    check("rand_pending", exp_q.size(), 0);

    // Small instance: clear beats a non-empty FIFO in the same cycle.
    @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    @(posedge clk);
    #1;
    s_empty = 1'b0;
    s_clear_req = 1'b1;
    @(negedge clk);
    check("clr_prio_no_rd", s_rd_en, 0);
    @(posedge clk);
    #1;
    s_clear_req = 1'b0;
    s_sweep(n, bad);
    check("clr1_writes", n, S_H * S_V);
    check("clr1_bad", bad, 0);
    check("post_clr_rd", s_rd_en, 1);
    @(posedge clk);
    #1;
    s_rd_data = mk_word(10'd3, 9'd1, 6'h01, 6'h3E, 6'h10);
    s_empty = 1'b1;
    s_clear_req = 1'b1;
    @(posedge clk);
    #1;
    s_clear_req = 1'b0;
    @(negedge clk);
    check("queued_we", s_mem_we, 1);
    check("queued_addr", s_mem_addr, 43);
    check("queued_data", s_mem_wdata, 18'h01F90);
    check("queued_busy", s_clear_busy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("queued_pix", s_pix, 1);
    check("deferred_busy_lo", s_clear_busy, 0);
    @(posedge clk);
    #1;
    s_sweep(n, bad);
    check("clr2_writes", n, S_H * S_V);
    check("clr2_bad", bad, 0);

    // Reset in the middle of a sweep, then a fresh clear.
    @(posedge clk);
    #1;
    s_clear_req = 1'b1;
    @(posedge clk);
    #1;
    s_clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clk);
      found = (s_mem_addr == 11'd1000);
    end
    check("mid_clr_reached", found, 1);
    s_rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_we", s_mem_we, 0);
    check("mid_rst_busy", s_clear_busy, 0);
    check("mid_rst_addr", s_mem_addr, 0);
    check("mid_rst_pix", s_pix, 0);
    s_rst_n = 1'b1;
    s_clear_req = 1'b1;
    @(posedge clk);
    #1;
    s_clear_req = 1'b0;
    check("restart_addr", s_mem_addr, 0);
    check("restart_busy", s_clear_busy, 1);
    check("restart_we", s_mem_we, 1);
    s_sweep(n, bad);
    check("clr3_writes", n, S_H * S_V);
    check("clr3_bad", bad, 0);
    check("clr_no_pix", s_pix, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
